piezo_txrx_sequencer: RTL and testbench
=======================================

// Module: piezo_txrx_sequencer
// PURPOSE
//  Arbitrates a shared piezo transducer between transmit and receive for N enable-request sources
//  (PTP interface, RTC, piezo_ctl, ...). Inserts break-before-make guard time and post-TX receive
//  blanking. Timestamps the first echo edge with the PTP time base.
//  Replaces the fixed two-source OR and the ENABLE_PIEZO_IN = !ENABLE_PIEZO inversion in the top level.
// PARAMETERS
//  N_REQ         2    number of TX enable-request sources
//  GUARD_CYCLES  4    dead time, TX and RX both off; 0 treated as 1
//  BLANK_CYCLES  16   cycles after RX re-enable during which echo edges are ignored; 0 = no blanking
//  TIME_W        32   width of time base and timestamp
// PORTS
//  iCLK         in   1       system clock
//  iRESETn      in   1       reset, synchronous, active-low
//  iREQ         in   N_REQ   TX requests, synchronous to iCLK, level-sensitive
//  iREQ_MASK    in   N_REQ   1 = source enabled
//  iPIEZO_IN    in   1       asynchronous echo comparator input
//  iTIME        in   TIME_W  free-running PTP time
//  iEVT_ACK     in   1       consumer acknowledge for the captured event
//  oTX_EN       out  1       drive enable for the piezo driver
//  oRX_EN       out  1       enable for the receive front end
//  oBUSY        out  1       1 in any state other than LISTEN
//  oEVT_VALID   out  1       timestamp pending
//  oEVT_TIME    out  TIME_W  captured iTIME of the echo edge
//  oOVERRUN     out  1       sticky: an edge arrived while oEVT_VALID=1
//  oSTATE       out  3       FSM state: LISTEN=0, GUARD_TX=1, TX=2, GUARD_RX=3, BLANK=4
// BEHAVIOUR
//  Reset values (iRESETn=0 at a posedge):
//   - state LISTEN
//   - oTX_EN=0, oRX_EN=1, oBUSY=0
//   - oEVT_VALID=0, oEVT_TIME=0, oOVERRUN=0
//   - synchroniser flops cleared, guard/blank counter cleared
//   - reset mid-TX drops oTX_EN on the next edge
//  req = |(iREQ & iREQ_MASK). All outputs are registered. oTX_EN=1 iff state==TX. oRX_EN=1 iff state is LISTEN or BLANK.
//   oTX_EN and oRX_EN are never 1 together.
//  FSM transitions:
//   - LISTEN: req=1 -> GUARD_TX, counter loaded.
//   - GUARD_TX: lasts exactly G=max(GUARD_CYCLES,1) cycles, then -> TX, even if req dropped.
//   - TX: stays while req=1 (minimum 1 cycle); req=0 -> GUARD_RX.
//   - GUARD_RX: lasts G cycles, then -> BLANK, or -> LISTEN if BLANK_CYCLES=0. req during GUARD_RX is held off until the guard completes.
//   - BLANK: lasts BLANK_CYCLES cycles, then -> LISTEN. req=1 in BLANK aborts blanking -> GUARD_TX.
//   - req=1 in the final LISTEN-entry cycle behaves as in LISTEN.
//  Latency: req rising at edge k -> GUARD_TX at k+1 -> oTX_EN=1 at k+1+G. req falling -> oTX_EN=0 on the next edge.
//  Echo path:
//   - iPIEZO_IN goes through a 2-flop synchroniser and a 3rd flop for edge detect.
//   - A rising edge is detected when s2=1 and s3=0, i.e. 2-3 cycles after the pin rises.
//   - Edges count only when state==LISTEN on the detect cycle; edges in other states are discarded with no flag.
//  Event capture:
//   - Detect with oEVT_VALID=0: next edge sets oEVT_VALID=1 and oEVT_TIME=iTIME sampled on the detect cycle.
//   - Detect with oEVT_VALID=1: oOVERRUN<=1; oEVT_TIME is kept (first edge wins).
//   - iEVT_ACK=1 clears oEVT_VALID and oOVERRUN on the next edge.
//   - Simultaneous ACK and detect: the new capture wins (oEVT_VALID stays 1, new time, oOVERRUN=0).
//  iTIME wrap-around needs no special handling; the captured value is raw.
//  Counter width: clog2(max(G,BLANK_CYCLES)+1). Counter terminates at 1, not 0.
// TESTING
//  1. Defaults, iREQ[0] pulses high cycles 10-29 -> GUARD_TX 11-14, oTX_EN=1 15-30, GUARD_RX 31-34, BLANK 35-50, LISTEN at 51.
//  2. Echo rises at cycle 60, iTIME=cycle count -> oEVT_VALID=1 at cycle 63, oEVT_TIME=62. Second rise at 80 without ack -> oOVERRUN=1, time stays 62.
//  3. Echo pulses during TX and during BLANK -> no oEVT_VALID, no oOVERRUN.
//  4. iREQ_MASK=2'b10 with iREQ=2'b01 -> stays LISTEN. Both sources high with staggered drop -> a single TX window until the last one drops.
//  5. req re-asserted at BLANK cycle 5 -> GUARD_TX next cycle. Re-asserted in GUARD_RX -> GUARD_RX completes, then BLANK, then GUARD_TX.
//  6. Reset asserted during TX -> oTX_EN=0 and oRX_EN=1 after one edge; ack and detect in the same cycle -> new timestamp latched, oOVERRUN=0.

Source files
------------

// File: rtl/piezo_txrx_sequencer.sv
// Shares one piezo transducer between TX and RX for several request sources, with
// break-before-make guard time, post-TX echo blanking and first-echo timestamping.
module piezo_txrx_sequencer #(
  parameter int N_REQ        = 2,
  parameter int GUARD_CYCLES = 4,
  parameter int BLANK_CYCLES = 16,
  parameter int TIME_W       = 32
) (
  input  logic              iCLK,
  input  logic              iRESETn,
  input  logic [N_REQ-1:0]  iREQ,
  input  logic [N_REQ-1:0]  iREQ_MASK,
  input  logic              iPIEZO_IN,
  input  logic [TIME_W-1:0] iTIME,
  input  logic              iEVT_ACK,
  output logic              oTX_EN,
  output logic              oRX_EN,
  output logic              oBUSY,
  output logic              oEVT_VALID,
  output logic [TIME_W-1:0] oEVT_TIME,
  output logic              oOVERRUN,
  output logic [2:0]        oSTATE
);

  localparam int G_EFF   = (GUARD_CYCLES < 1) ? 1 : GUARD_CYCLES;
  localparam int CNT_MAX = (G_EFF > BLANK_CYCLES) ? G_EFF : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] G_LOAD   = CNT_W'(G_EFF);
  localparam logic [CNT_W-1:0] B_LOAD   = CNT_W'(BLANK_CYCLES);

  typedef enum logic [2:0] {
    LISTEN   = 3'd0,
    GUARD_TX = 3'd1,
    TX       = 3'd2,
    GUARD_RX = 3'd3,
    BLANK    = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             req;
  logic             tx_en;
  logic             rx_en;
  logic             busy;
  logic             tx_en_next;
  logic             rx_en_next;
  logic             busy_next;

  logic              sync1;
  logic              sync2;
  logic              sync3;
  logic              detect;
  logic              evt_valid;
  logic [TIME_W-1:0] evt_time;
  logic              overrun;

  assign req = |(iREQ & iREQ_MASK);

  // State, dwell counter and registered enables; the enables follow the next state
  // so they always equal the decode of the registered state.
  always_ff @(posedge iCLK) begin
    if (!iRESETn) begin
      state <= LISTEN;
      cnt   <= CNT_ZERO;
      tx_en <= 1'b0;
      rx_en <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      tx_en <= tx_en_next;
      rx_en <= rx_en_next;
      busy  <= busy_next;
    end
  end

  // Next-state and counter; the counter is loaded on entry and the phase ends when it reads 1.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      LISTEN: begin
        if (req) begin
          state_next = GUARD_TX;
          cnt_next   = G_LOAD;
        end else begin
          state_next = LISTEN;
          cnt_next   = CNT_ZERO;
        end
      end
      GUARD_TX: begin
        if (cnt <= CNT_ONE) begin
          state_next = TX;
          cnt_next   = CNT_ZERO;
        end else begin
          state_next = GUARD_TX;
          cnt_next   = cnt - CNT_ONE;
        end
      end
      TX: begin
        if (!req) begin
          state_next = GUARD_RX;
          cnt_next   = G_LOAD;
        end else begin
          state_next = TX;
          cnt_next   = CNT_ZERO;
        end
      end
      GUARD_RX: begin
        if (cnt <= CNT_ONE) begin
          if (HAS_BLANK) begin
            state_next = BLANK;
            cnt_next   = B_LOAD;
          end else begin
            state_next = LISTEN;
            cnt_next   = CNT_ZERO;
          end
        end else begin
          state_next = GUARD_RX;
          cnt_next   = cnt - CNT_ONE;
        end
      end
      BLANK: begin
        if (req) begin
          state_next = GUARD_TX;
          cnt_next   = G_LOAD;
        end else if (cnt <= CNT_ONE) begin
          state_next = LISTEN;
          cnt_next   = CNT_ZERO;
        end else begin
          state_next = BLANK;
          cnt_next   = cnt - CNT_ONE;
        end
      end
      default: begin
        state_next = LISTEN;
        cnt_next   = CNT_ZERO;
      end
    endcase
  end

  // Output decode of the upcoming state; TX and RX enables are mutually exclusive by construction.
  always_comb begin
    tx_en_next = 1'b0;
    rx_en_next = 1'b0;
    busy_next  = 1'b1;
    case (state_next)
      LISTEN: begin
        rx_en_next = 1'b1;
        busy_next  = 1'b0;
      end
      TX:      tx_en_next = 1'b1;
      BLANK:   rx_en_next = 1'b1;
      default: busy_next  = 1'b1;
    endcase
  end

  // Echo pin synchroniser plus one delay flop for rising-edge detection.
  always_ff @(posedge iCLK) begin
    if (!iRESETn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= iPIEZO_IN;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign detect = sync2 & ~sync3 & (state == LISTEN);

  // Event capture: first edge wins until acknowledged, but a capture coinciding with an ack takes over.
  always_ff @(posedge iCLK) begin
    if (!iRESETn) begin
      evt_valid <= 1'b0;
      evt_time  <= {TIME_W{1'b0}};
      overrun   <= 1'b0;
    end else if (detect) begin
      if (!evt_valid || iEVT_ACK) begin
        evt_valid <= 1'b1;
        evt_time  <= iTIME;
        overrun   <= 1'b0;
      end else begin
        overrun   <= 1'b1;
      end
    end else if (iEVT_ACK) begin
      evt_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      evt_valid <= evt_valid;
    end
  end

  assign oTX_EN     = tx_en;
  assign oRX_EN     = rx_en;
  assign oBUSY      = busy;
  assign oEVT_VALID = evt_valid;
  assign oEVT_TIME  = evt_time;
  assign oOVERRUN   = overrun;
  assign oSTATE     = state;

endmodule

// File: tb/tb_piezo_txrx_sequencer.sv
// Directed bench for piezo_txrx_sequencer: a phase/age model with a pin-history echo
// detector is checked every cycle, plus literal expectations at key cycles.
module tb_piezo_txrx_sequencer;

  localparam int G = 4;
  localparam int B = 16;
  localparam int P_LISTEN = 0;
  localparam int P_GTX    = 1;
  localparam int P_TX     = 2;
  localparam int P_GRX    = 3;
  localparam int P_BLANK  = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  mask = 2'b11;
  logic        pin = 1'b0;
  logic [31:0] time_in = 32'd0;
  logic        ack = 1'b0;
  logic        tx_en;
  logic        rx_en;
  logic        busy;
  logic        evt_valid;
  logic [31:0] evt_time;
  logic        overrun;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // model state: phase and how many cycles it has been held
  int          m_phase = P_LISTEN;
  int          m_age = 0;
  logic [2:0]  m_hist = 3'b000;
  bit          m_valid = 1'b0;
  logic [31:0] m_time = 32'd0;
  bit          m_ovr = 1'b0;
  int          n_phase;
  int          n_age;
  logic [2:0]  n_hist;
  bit          n_valid;
  logic [31:0] n_time;
  bit          n_ovr;

  piezo_txrx_sequencer #(
    .N_REQ(2), .GUARD_CYCLES(G), .BLANK_CYCLES(B), .TIME_W(32)
  ) dut (
    .iCLK(clk), .iRESETn(rstn), .iREQ(req), .iREQ_MASK(mask),
    .iPIEZO_IN(pin), .iTIME(time_in), .iEVT_ACK(ack),
    .oTX_EN(tx_en), .oRX_EN(rx_en), .oBUSY(busy),
    .oEVT_VALID(evt_valid), .oEVT_TIME(evt_time), .oOVERRUN(overrun),
    .oSTATE(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_compute();
    bit any_req;
    bit det;
    any_req = |(req & mask);
    det = m_hist[1] && !m_hist[2] && (m_phase == P_LISTEN);
    if (!rstn) begin
      n_phase = P_LISTEN; n_age = 0; n_hist = 3'b000;
      n_valid = 1'b0; n_time = 32'd0; n_ovr = 1'b0;
    end else begin
      n_phase = m_phase;
      case (m_phase)
        P_LISTEN: if (any_req) n_phase = P_GTX;
        P_GTX:    if (m_age + 1 >= G) n_phase = P_TX;
        P_TX:     if (!any_req) n_phase = P_GRX;
        P_GRX:    if (m_age + 1 >= G) n_phase = (B == 0) ? P_LISTEN : P_BLANK;
        P_BLANK:  if (any_req) n_phase = P_GTX;
                  else if (m_age + 1 >= B) n_phase = P_LISTEN;
        default:  n_phase = P_LISTEN;
      endcase
      n_age = (n_phase != m_phase) ? 0 : m_age + 1;
      n_hist = {m_hist[1:0], pin};
      n_valid = m_valid; n_time = m_time; n_ovr = m_ovr;
      if (det && (!m_valid || ack)) begin
        n_valid = 1'b1; n_time = time_in; n_ovr = 1'b0;
      end else if (det) begin
        n_ovr = 1'b1;
      end else if (ack) begin
        n_valid = 1'b0; n_ovr = 1'b0;
      end
    end
  endtask

  task automatic tick();
    model_compute();
    @(posedge clk);
    m_phase = n_phase; m_age = n_age; m_hist = n_hist;
    m_valid = n_valid; m_time = n_time; m_ovr = n_ovr;
    cyc++;
    #1;
    time_in = cyc;
    chk_en = 1'b1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("state", state, m_phase);
        check("tx_en", tx_en, m_phase == P_TX);
        check("rx_en", rx_en, (m_phase == P_LISTEN) || (m_phase == P_BLANK));
        check("busy", busy, m_phase != P_LISTEN);
        check("evt_valid", evt_valid, m_valid);
        check("evt_time", evt_time, m_time);
        check("overrun", overrun, m_ovr);
        check("tx_rx_excl", tx_en & rx_en, 1'b0);
      end
    end
  end

  initial begin
    // reset
    run_to(3);
    check("rst_tx", tx_en, 1'b0);
    check("rst_rx", rx_en, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_state", state, 3'd0);
    check("rst_valid", evt_valid, 1'b0);
    check("rst_time", evt_time, 32'd0);
    check("rst_ovr", overrun, 1'b0);
    rstn = 1'b1;

    // basic TX window
    run_to(10); req = 2'b01;
    run_to(11); check("t1_gtx_first", state, 3'd1);
    run_to(14); check("t1_gtx_last", state, 3'd1);
    check("t1_tx_off_14", tx_en, 1'b0);
    run_to(15); check("t1_tx_on_15", tx_en, 1'b1);
    run_to(30); check("t1_tx_on_30", tx_en, 1'b1);
    req = 2'b00;
    run_to(31); check("t1_grx", state, 3'd3);
    check("t1_tx_off_31", tx_en, 1'b0);
    run_to(35); check("t1_blank_first", state, 3'd4);
    run_to(50); check("t1_blank_last", state, 3'd4);
    run_to(51); check("t1_listen", state, 3'd0);

    // echo capture and overrun
    run_to(60); pin = 1'b1;
    run_to(62); check("t2_valid_62", evt_valid, 1'b0);
    run_to(63); check("t2_valid_63", evt_valid, 1'b1);
    check("t2_time", evt_time, 32'd62);
    run_to(66); pin = 1'b0;
    run_to(80); pin = 1'b1;
    run_to(84); check("t2_ovr", overrun, 1'b1);
    check("t2_time_kept", evt_time, 32'd62);
    run_to(85); pin = 1'b0;
    run_to(90); ack = 1'b1;
    run_to(91); ack = 1'b0;
    check("t2_ack_valid", evt_valid, 1'b0);
    check("t2_ack_ovr", overrun, 1'b0);

    // echoes during TX and BLANK are discarded
    run_to(100); req = 2'b01;
    run_to(108); pin = 1'b1;
    run_to(112); pin = 1'b0;
    run_to(120); req = 2'b00;
    run_to(128); check("t3_in_blank", state, 3'd4);
    pin = 1'b1;
    run_to(132); pin = 1'b0;
    run_to(145); check("t3_no_valid", evt_valid, 1'b0);
    check("t3_no_ovr", overrun, 1'b0);

    // masking and overlapping sources
    run_to(150); mask = 2'b10; req = 2'b01;
    run_to(160); check("t4_masked", state, 3'd0);
    check("t4_masked_busy", busy, 1'b0);
    run_to(170); mask = 2'b11; req = 2'b11;
    run_to(190); req = 2'b10;
    run_to(195); check("t4_still_tx", tx_en, 1'b1);
    run_to(200); req = 2'b00;
    run_to(201); check("t4_grx", state, 3'd3);

    // re-request in BLANK and in GUARD_RX
    run_to(209); check("t5_blank5", state, 3'd4);
    req = 2'b01;
    run_to(210); check("t5_abort", state, 3'd1);
    run_to(220); req = 2'b00;
    run_to(222); check("t5_in_grx", state, 3'd3);
    req = 2'b01;
    run_to(224); check("t5_grx_hold", state, 3'd3);
    run_to(225); check("t5_blank_once", state, 3'd4);
    run_to(226); check("t5_gtx", state, 3'd1);

    // reset during TX
    run_to(235); check("t6_tx_before", tx_en, 1'b1);
    rstn = 1'b0;
    run_to(236); check("t6_rst_tx", tx_en, 1'b0);
    check("t6_rst_rx", rx_en, 1'b1);
    check("t6_rst_state", state, 3'd0);
    rstn = 1'b1; req = 2'b00;

    // ack coinciding with detect
    run_to(240); pin = 1'b1;
    run_to(243); check("t6_first_time", evt_time, 32'd242);
    run_to(244); pin = 1'b0;
    run_to(246); pin = 1'b1;
    run_to(248); pin = 1'b0;
    run_to(250); check("t6_ovr_set", overrun, 1'b1);
    pin = 1'b1;
    run_to(252); ack = 1'b1;
    run_to(253); ack = 1'b0;
    check("t6_both_valid", evt_valid, 1'b1);
    check("t6_both_time", evt_time, 32'd252);
    check("t6_both_ovr", overrun, 1'b0);
    run_to(256); pin = 1'b0;
    run_to(262);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
